sequential_divider: RTL and testbench
=====================================

Name: sequential_divider

Overview:
- Radix-2 restoring divider; the inverse of the team's shift-add sequentialMultiplier.
- Divides a 2*WIDTH-bit dividend, such as a multiplier product, by a WIDTH-bit divisor. Produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Retires one quotient bit per clock, under the same start/done handshake as the multiplier.
- Used in the arithmetic assignment datapath to recover multiplier operands and for scaling.

Parameters:
- WIDTH, 8, divisor/remainder width. Dividend and quotient are 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- start  input  1  request; sampled only when idle.
- dividend  input  2*WIDTH  unsigned numerator; sampled when start is accepted.
- divisor  input  WIDTH  unsigned denominator; sampled when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.
- quotient  output  2*WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  error flag for the last operation; held with the results.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Iteration counter and internal registers cleared. Reset overrides start.
- Reset mid-operation aborts the division. No done pulse is produced for the aborted job.
- States: IDLE, BUSY. done is a registered pulse, not a state.
- IDLE, start=1 at edge k, divisor!=0:
  - Capture operands.
  - Partial remainder R (WIDTH+1 bits) = 0; Q = dividend; counter = 0.
  - Go to BUSY; busy=1 from edge k; div_by_zero cleared.
- IDLE, start=1 at edge k, divisor==0:
  - Stay in IDLE; busy stays 0.
  - At edge k: done=1, div_by_zero=1, quotient = all ones, remainder = 0.
- BUSY, each edge performs one iteration:
  - Shift {R,Q} left by one bit.
  - trial = R - {0,divisor}.
  - If trial is non-negative (MSB clear): R = trial, Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - counter increments.
- On the edge completing iteration 2*WIDTH (edge k+2*WIDTH): quotient<=Q, remainder<=R[WIDTH-1:0], done<=1, busy<=0, state=IDLE.
- Latency: done is high in the cycle after edge k+2*WIDTH. That is 2*WIDTH cycles after acceptance; 16 for WIDTH=8.
- done lasts exactly one cycle and is cleared on the following edge unless a new result completes.
- start while BUSY is ignored; operand changes during BUSY have no effect.
- Back-to-back: start sampled high in the cycle where done=1 is accepted (state is IDLE). The new job's busy rises on that edge; prior results stay valid on the outputs until the new job's completion edge.
- start held high continuously causes repeated operations with no dead cycle besides the done cycle.
- Arithmetic is unsigned. Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
- Quotient is 2*WIDTH bits wide, so no overflow case exists.

Decomposition:
- Shared package arith_pkg:
  - WIDTH default.
  - State encoding IDLE/BUSY.
  - Counter width constant $clog2(2*WIDTH+1).
- One natural combinational sub-module: div_step, which does the shift, trial subtract and quotient-bit select (inputs R, Q, divisor; outputs next R, next Q). Keeps the FSM file small and allows the step to be unrolled later.

Test Plan:
- Reset, then start with dividend=16, divisor=4 → done after 16 cycles; quotient=4, remainder=0, div_by_zero=0. Inverse of multiplier 4*4.
- dividend=30, divisor=6, then dividend=100, divisor=7, issued back-to-back with start high in the done cycle → quotient 5 rem 0, then quotient 14 rem 2. Each done is a single-cycle pulse.
- dividend=65535, divisor=1 → quotient=65535, remainder=0. dividend=65025, divisor=255 → quotient=255, remainder=0.
- dividend=1234, divisor=0 → done the next cycle with div_by_zero=1, quotient=16'hFFFF, remainder=0, busy never asserted.
- Start 200/9. Toggle start and change operands to 50/5 at cycle 5 → ignored; result is quotient 22 rem 2.
- Start 200/9. Assert rst=0 at cycle 8 → all outputs zero on the next edge, no done pulse. A subsequent 45/9 gives quotient 5 rem 0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential divider and its datapath step.
package arith_pkg;

  localparam int WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH);

endpackage

// File: rtl/sequential_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface sequential_divider_if
  import arith_pkg::*;
#(
  parameter int WIDTH = arith_pkg::WIDTH
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration: shift {R,Q}, trial subtract, select quotient bit.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = arith_pkg::WIDTH
) (
  input  logic [WIDTH:0]     r,
  input  logic [2*WIDTH-1:0] q,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH:0]     r_next,
  output logic [2*WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;

  // An extra guard bit makes the sign of the trial difference explicit.
  always_comb begin
    shifted_s = {r, q[2*WIDTH-1]};
    trial_s   = shifted_s - {2'b00, divisor};
    if (trial_s[WIDTH+1] == 1'b0) begin
      r_next = trial_s[WIDTH:0];
      q_next = {q[2*WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted_s[WIDTH:0];
      q_next = {q[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
module sequential_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = arith_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  sequential_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(2 * WIDTH - 1);

  state_t               state_r, state_s;
  logic [WIDTH:0]       r_r, r_s, step_r_s;
  logic [2*WIDTH-1:0]   q_r, q_s, step_q_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [WIDTH-1:0]     dvs_r, dvs_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic [2*WIDTH-1:0]   quot_r, quot_s;
  logic [WIDTH-1:0]     rem_r, rem_s;
  logic                 dbz_r, dbz_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_r),
    .q       (q_r),
    .divisor (dvs_r),
    .r_next  (step_r_s),
    .q_next  (step_q_s)
  );

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      r_r     <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      dvs_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      r_r     <= r_s;
      q_r     <= q_s;
      cnt_r   <= cnt_s;
      dvs_r   <= dvs_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      quot_r  <= quot_s;
      rem_r   <= rem_s;
      dbz_r   <= dbz_s;
    end
  end

  // Next-state and next-output logic; done is a one-cycle pulse by default-clearing.
  always_comb begin
    state_s = state_r;
    r_s     = r_r;
    q_s     = q_r;
    cnt_s   = cnt_r;
    dvs_s   = dvs_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    quot_s  = quot_r;
    rem_s   = rem_r;
    dbz_s   = dbz_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != {WIDTH{1'b0}}) begin
            dvs_s   = bus.divisor;
            r_s     = '0;
            q_s     = bus.dividend;
            cnt_s   = '0;
            busy_s  = 1'b1;
            dbz_s   = 1'b0;
            state_s = BUSY;
          end else begin
            // Zero divisor completes immediately with a saturated quotient.
            done_s  = 1'b1;
            dbz_s   = 1'b1;
            quot_s  = {(2*WIDTH){1'b1}};
            rem_s   = {WIDTH{1'b0}};
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        r_s   = step_r_s;
        q_s   = step_q_s;
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == LAST_ITER) begin
          quot_s  = step_q_s;
          rem_s   = step_r_s[WIDTH-1:0];
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized and directed bench for sequential_divider against an arithmetic reference model.
module tb_sequential_divider;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc_cnt;
  int   acc_cyc;

  sequential_divider_if #(.WIDTH(W)) bus ();

  sequential_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    acc_cyc   = cyc_cnt;
    bus.start = 1'b0;
  endtask

  task automatic await_done();
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) check_value("timeout", {31'd0, bus.done}, 32'd1);
  endtask

  // Reference: plain unsigned division; zero divisor saturates the quotient.
  task automatic expect_result(input string tag, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq;
    logic [7:0]  er;
    int          elat;
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = 8'd0; elat = 0;
    end else begin
      eq = a / b; er = a % b; elat = 2 * W;
    end
    check_value({tag, "_quot"}, {16'd0, bus.quotient}, {16'd0, eq});
    check_value({tag, "_rem"}, {24'd0, bus.remainder}, {24'd0, er});
    check_value({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, (b == 8'd0)});
    check_value({tag, "_lat"}, cyc_cnt - acc_cyc, elat);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b);
    launch(a, b);
    check_value({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, (b != 8'd0)});
    await_done();
    expect_result(tag, a, b);
    @(posedge clk);
    #1;
    check_value({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    check_value({tag, "_hold"}, {16'd0, bus.quotient}, (b == 8'd0) ? 32'hFFFF : 32'(a / b));
  endtask

  initial begin
    int dones;
    logic [15:0] ra;
    logic [7:0]  rb;
    tests = 0; fails = 0; cyc_cnt = 0; acc_cyc = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_value("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_value("rst_done", {31'd0, bus.done}, 32'd0);
    check_value("rst_quot", {16'd0, bus.quotient}, 32'd0);
    check_value("rst_rem", {24'd0, bus.remainder}, 32'd0);
    check_value("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    run_op("d16_4", 16'd16, 8'd4);

    // Back-to-back: second start presented during the done cycle.
    launch(16'd30, 8'd6);
    await_done();
    expect_result("b2b_a", 16'd30, 8'd6);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    acc_cyc   = cyc_cnt;
    bus.start = 1'b0;
    check_value("b2b_pulse", {31'd0, bus.done}, 32'd0);
    check_value("b2b_busy", {31'd0, bus.busy}, 32'd1);
    check_value("b2b_held", {16'd0, bus.quotient}, 32'd5);
    await_done();
    expect_result("b2b_b", 16'd100, 8'd7);

    run_op("max_1", 16'd65535, 8'd1);
    run_op("sq255", 16'd65025, 8'd255);
    run_op("dbz", 16'd1234, 8'd0);

    // Start and operand changes while busy must be ignored.
    launch(16'd200, 8'd9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    await_done();
    expect_result("ignore", 16'd200, 8'd9);

    // Reset mid-operation aborts without a done pulse.
    launch(16'd200, 8'd9);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_value("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_value("abort_quot", {16'd0, bus.quotient}, 32'd0);
    check_value("abort_rem", {24'd0, bus.remainder}, 32'd0);
    check_value("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check_value("abort_nodone", dones, 32'd0);
    run_op("post_rst", 16'd45, 8'd9);

    // Randomized operands, including occasional zero and small divisors.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0:       rb = 8'd0;
        1:       rb = 8'($urandom_range(1, 4));
        default: rb = 8'($urandom_range(1, 255));
      endcase
      run_op("rand", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
